// File: rtl/datamem_responder_if.sv
// LD/ST request channel (valid/ready) and fixed-latency read-response channel.
interface datamem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/datamem_responder.sv
// Data-memory responder: posted stores through a write buffer, loads forwarded from newest buffered store.
// Latency: load response READ_LAT cycles after accept; stores retire in the background, WR_CYCLES each.
// Backpressure: req_ready low while a load is outstanding or the write buffer is full; no response backpressure.
module datamem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int READ_LAT  = 2,
    parameter int WB_DEPTH  = 4,
    parameter int WR_CYCLES = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    datamem_responder_if.slave          bus,
    output logic [$clog2(WB_DEPTH):0]   wb_count,
    output logic                        idle
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DR_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int WT_W  = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [CNT_W-1:0] WB_FULL   = CNT_W'(WB_DEPTH);
    localparam logic [DR_W-1:0]  WR_LAST   = DR_W'(WR_CYCLES - 1);
    localparam logic [WT_W-1:0]  WAIT_INIT = WT_W'((READ_LAT >= 2) ? READ_LAT - 2 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WT_W-1:0]  wait_q, wait_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DR_W-1:0]  drain_q, drain_d;
    logic [15:0]      cap_q, cap_d;
    logic [15:0]      rsp_data_q, rsp_data_d;

    logic [ADDR_BITS-1:0] wb_addr_q [WB_DEPTH];
    logic [15:0]          wb_data_q [WB_DEPTH];
    logic [15:0]          mem_q     [DEPTH];

    logic                 ready;
    logic                 accept, push, pop, load_acc, busy;
    logic [ADDR_BITS-1:0] addr_idx;
    logic [PTR_W-1:0]     fwd_idx;
    logic [15:0]          fwd_val;
    logic                 unused_addr_hi;

    assign addr_idx       = bus.req_addr[ADDR_BITS-1:0];
    assign unused_addr_hi = ^bus.req_addr[15:ADDR_BITS];

    assign ready         = reset && (state_q == ST_IDLE) && (count_q < WB_FULL);
    assign bus.req_ready = ready;
    assign accept        = bus.req_valid && ready;
    assign push          = accept && bus.req_we;
    assign load_acc      = accept && !bus.req_we;

    assign busy = (count_q != '0);
    assign pop  = busy && (drain_q == WR_LAST);

    // Walk oldest to newest so the last hit is the youngest store to this word.
    always_comb begin
        fwd_val = mem_q[addr_idx];
        fwd_idx = head_q;
        for (int i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (wb_addr_q[fwd_idx] == addr_idx)) begin
                fwd_val = wb_data_q[fwd_idx];
            end
        end
    end

    always_comb begin
        drain_d = (!busy || pop) ? '0 : drain_q + DR_W'(1);
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cap_d   = cap_q;
        case (state_q)
            ST_IDLE: begin
                if (load_acc) begin
                    cap_d   = fwd_val;
                    wait_d  = WAIT_INIT;
                    state_d = (READ_LAT == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) state_d = ST_RESP;
                else              wait_d  = wait_q - WT_W'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // With a one-cycle latency the capture register is bypassed on the accept edge.
        rsp_data_d = rsp_data_q;
        if (state_d == ST_RESP) begin
            rsp_data_d = load_acc ? fwd_val : cap_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            drain_q    <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            drain_q    <= drain_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Buffer entries and storage are plain RAM: only the pointers carry reset.
    always_ff @(posedge clock) begin
        if (push) begin
            wb_addr_q[tail_q] <= addr_idx;
            wb_data_q[tail_q] <= bus.req_wdata;
        end
        if (pop) begin
            mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
        end
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign wb_count      = count_q;
    assign idle          = (state_q == ST_IDLE) && (count_q == '0);
endmodule

// File: tb/tb_datamem_responder.sv
// Directed bench for datamem_responder: READ_LAT=2 instance for most steps, READ_LAT=1 instance for back-to-back loads.
module tb_datamem_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    datamem_responder_if bus0();
    datamem_responder_if bus1();
    logic [2:0] wbc0, wbc1;
    logic       idle0, idle1;

    datamem_responder #(.ADDR_BITS(8), .READ_LAT(2), .WB_DEPTH(4), .WR_CYCLES(2)) u_dut (
        .clock(clock), .reset(reset), .bus(bus0), .wb_count(wbc0), .idle(idle0)
    );
    datamem_responder #(.ADDR_BITS(8), .READ_LAT(1), .WB_DEPTH(4), .WR_CYCLES(2)) u_dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .wb_count(wbc1), .idle(idle1)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [2:0] exp_cnt [10] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd4};
    logic       exp_rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        b2b_vld [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        b2b_rdy [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] b2b_dat [4] = '{16'h1234, 16'h1234, 16'h5678, 16'h5678};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready0(input string tag);
        int n = 0;
        while (!bus0.req_ready && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(bus0.req_ready), 32'd1);
    endtask

    task automatic store0(input logic [15:0] a, input logic [15:0] d);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = a;
        bus0.req_wdata = d;
        wait_ready0("store_ready");
        tick();
        bus0.req_valid = 1'b0;
    endtask

    task automatic load0(input logic [15:0] a, input logic [15:0] exp, input string tag);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = a;
        wait_ready0("load_ready");
        tick();
        bus0.req_valid = 1'b0;
        check({tag, "_vld_t0"}, 32'(bus0.rsp_valid), 32'd0);
        tick();
        check({tag, "_vld_t1"}, 32'(bus0.rsp_valid), 32'd1);
        check({tag, "_data"}, 32'(bus0.rsp_data), 32'(exp));
        tick();
        check({tag, "_vld_t2"}, 32'(bus0.rsp_valid), 32'd0);
        check({tag, "_hold"}, 32'(bus0.rsp_data), 32'(exp));
        check({tag, "_rdy_t2"}, 32'(bus0.req_ready), 32'd1);
    endtask

    task automatic wait_idle0(input string tag);
        int n = 0;
        while (!idle0 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(idle0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  m;
        logic acc;

        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

        // Reset values
        tick();
        tick();
        check("rst_rdy", 32'(bus0.req_ready), 32'd0);
        check("rst_rsp_vld", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rsp_dat", 32'(bus0.rsp_data), 32'd0);
        check("rst_wbc", 32'(wbc0), 32'd0);
        check("rst_idle", 32'(idle0), 32'd1);
        reset = 1'b1;
        tick();
        check("rel_rdy", 32'(bus0.req_ready), 32'd1);

        // 1: store then load after drain
        store0(16'h0010, 16'hBEEF);
        check("t1_wbc", 32'(wbc0), 32'd1);
        wait_idle0("t1_idle");
        load0(16'h0010, 16'hBEEF, "t1_ld");

        // 2: held-valid stream of 8 stores, buffer fills and throttles to one per 2 cycles
        n = 0;
        bus0.req_we = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus0.req_valid = (n < 8);
            bus0.req_addr  = 16'(32'h20 + n);
            bus0.req_wdata = 16'(32'hA000 + n);
            acc = bus0.req_valid && bus0.req_ready;
            tick();
            if (acc) n++;
            check($sformatf("t2_wbc_%0d", k), 32'(wbc0), 32'(exp_cnt[k]));
            check($sformatf("t2_rdy_%0d", k), 32'(bus0.req_ready), 32'(exp_rdy[k]));
        end
        bus0.req_valid = 1'b0;
        check("t2_accepts", 32'(n), 32'd8);
        wait_idle0("t2_idle");
        check("t2_wbc_end", 32'(wbc0), 32'd0);
        load0(16'h0021, 16'hA001, "t2_ld21");
        load0(16'h0027, 16'hA007, "t2_ld27");

        // 3: newest buffered store wins over older one to the same word
        store0(16'h0030, 16'h1111);
        store0(16'h0030, 16'h2222);
        check("t3_wbc", 32'(wbc0), 32'd2);
        load0(16'h0030, 16'h2222, "t3_fwd");
        wait_idle0("t3_idle");
        load0(16'h0030, 16'h2222, "t3_mem");

        // 4: upper address bits alias to the same word
        store0(16'h0105, 16'h00AA);
        load0(16'h0005, 16'h00AA, "t4_fwd");
        wait_idle0("t4_idle");
        load0(16'h0205, 16'h00AA, "t4_mem");

        // 5: reset during a read wait drops the response and the buffered store
        store0(16'h0020, 16'h5555);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 16'h0030;
        wait_ready0("t5_ld_ready");
        tick();
        bus0.req_valid = 1'b0;
        check("t5_wait_wbc", 32'(wbc0), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_rst_rdy", 32'(bus0.req_ready), 32'd0);
        check("t5_rst_wbc", 32'(wbc0), 32'd0);
        tick();
        check("t5_rst_vld_a", 32'(bus0.rsp_valid), 32'd0);
        tick();
        check("t5_rst_vld_b", 32'(bus0.rsp_valid), 32'd0);
        check("t5_rst_rdy_b", 32'(bus0.req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("t5_rel_idle", 32'(idle0), 32'd1);
        check("t5_rel_wbc", 32'(wbc0), 32'd0);
        check("t5_rel_dat", 32'(bus0.rsp_data), 32'd0);
        tick();
        check("t5_rel_vld", 32'(bus0.rsp_valid), 32'd0);
        load0(16'h0020, 16'hA000, "t5_mem_kept");

        // 6: READ_LAT=1 instance, back-to-back loads
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 16'h0050;
        bus1.req_wdata = 16'h1234;
        check("t6_st_rdy_a", 32'(bus1.req_ready), 32'd1);
        tick();
        bus1.req_addr  = 16'h0051;
        bus1.req_wdata = 16'h5678;
        check("t6_st_rdy_b", 32'(bus1.req_ready), 32'd1);
        tick();
        bus1.req_valid = 1'b0;
        check("t6_wbc", 32'(wbc1), 32'd2);
        m = 0;
        while (!idle1 && m < 100) begin
            tick();
            m++;
        end
        check("t6_idle", 32'(idle1), 32'd1);
        n = 0;
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = 16'h0050;
        for (int k = 0; k < 4; k++) begin
            acc = bus1.req_valid && bus1.req_ready;
            tick();
            if (acc) begin
                n++;
                bus1.req_addr = 16'h0051;
                if (n == 2) bus1.req_valid = 1'b0;
            end
            check($sformatf("t6_vld_%0d", k), 32'(bus1.rsp_valid), 32'(b2b_vld[k]));
            check($sformatf("t6_rdy_%0d", k), 32'(bus1.req_ready), 32'(b2b_rdy[k]));
            check($sformatf("t6_dat_%0d", k), 32'(bus1.rsp_data), 32'(b2b_dat[k]));
        end
        bus1.req_valid = 1'b0;
        check("t6_accepts", 32'(n), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
